pop_counter_pipe: RTL and testbench

- Pipelined, streaming successor to the combinational population counter, for wide data buses.
- Counts set bits of one WIDTH-bit beat per cycle using a registered 6-bit-LUT adder tree with valid/ready flow control.
- Adds a packet-accumulate mode: counts over a multi-beat packet are summed with saturation and emitted once, on the last beat.
- Sits between a streaming data source and statistics/feature-extraction logic.

---
 rtl/pop_counter_pipe.sv | 177 +++++++++++++++++
 tb/tb_pop_counter_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pop_counter_pipe.sv
// Streaming population counter: registered 6-input LUT leaves, a registered
// pairwise adder tree, and a final stage with optional saturating packet accumulation.
// Optional build macro POP_COUNTER_PIPE_MASK_EN adds i_mask; only bits set in both i_data and i_mask are counted.

module pop_counter_pipe_pop6 (
  input  logic [5:0] i_bits,
  output logic [2:0] o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int k = 0; k < 6; k++) o_cnt = o_cnt + 3'(i_bits[k]);
  end
endmodule

module pop_counter_pipe #(
  parameter int WIDTH     = 64,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_data,
`ifdef POP_COUNTER_PIPE_MASK_EN
  input  logic [WIDTH-1:0]     i_mask,
`endif
  input  logic                 i_accum,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ACC_WIDTH-1:0] o_data,
  output logic                 o_sat,
  output logic                 o_accum_active
);
  localparam int G      = (WIDTH + 5) / 6;
  localparam int LEVELS = $clog2(G);
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int TW     = (CW < 3) ? 3 : CW;  // leaves are 3 bits even when WIDTH is tiny

  if (WIDTH < 1) begin : g_chk_width
    $error("pop_counter_pipe: WIDTH must be at least 1");
  end
  if (ACC_WIDTH < CW) begin : g_chk_acc
    $error("pop_counter_pipe: ACC_WIDTH must be at least $clog2(WIDTH+1)");
  end

  function automatic int nodes(input int lvl);
    return (G + (1 << lvl) - 1) >> lvl;
  endfunction

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  logic                  r_valid;
  logic                  w_adv;
  logic [WIDTH-1:0]      w_bits;
  logic [6*G-1:0]        w_pad;
  logic [G-1:0][2:0]     w_leaf;
  logic [LEVELS:0]       r_vld_pipe;
  logic [LEVELS:0]       r_acc_pipe;
  logic [LEVELS:0]       r_last_pipe;
  logic [TW-1:0]         w_root;

  assign w_adv   = !r_valid || i_ready;
  assign o_ready = w_adv;

`ifdef POP_COUNTER_PIPE_MASK_EN
  assign w_bits = i_data & i_mask;
`else
  assign w_bits = i_data;
`endif
  assign w_pad = (6*G)'(w_bits);

  for (genvar g = 0; g < G; g++) begin : g_leaf_lut
    pop_counter_pipe_pop6 u_pop6 (.i_bits(w_pad[6*g +: 6]), .o_cnt(w_leaf[g]));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_pipe  <= '0;
      r_acc_pipe  <= '0;
      r_last_pipe <= '0;
    end else if (w_adv) begin
      r_vld_pipe[0]  <= i_valid;
      r_acc_pipe[0]  <= i_accum;
      r_last_pipe[0] <= i_last;
      for (int k = 1; k <= LEVELS; k++) begin
        r_vld_pipe[k]  <= r_vld_pipe[k-1];
        r_acc_pipe[k]  <= r_acc_pipe[k-1];
        r_last_pipe[k] <= r_last_pipe[k-1];
      end
    end
  end

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int NL = nodes(l);
    logic [NL-1:0][TW-1:0] r_node;
    if (l == 0) begin : g_leaf
      always_ff @(posedge i_clk)
        if (w_adv) for (int g = 0; g < G; g++) r_node[g] <= TW'(w_leaf[g]);
    end else begin : g_add
      // Previous level zero-extended to an even count so an odd tail adds 0.
      logic [2*NL-1:0][TW-1:0] w_in;
      assign w_in = (2*NL*TW)'(g_lvl[l-1].r_node);
      always_ff @(posedge i_clk)
        if (w_adv) for (int i = 0; i < NL; i++) r_node[i] <= w_in[2*i] + w_in[2*i+1];
    end
  end

  assign w_root = g_lvl[LEVELS].r_node[0];

  state_t                r_state, w_state_nx;
  logic [ACC_WIDTH-1:0]  r_acc, w_acc_nx;
  logic                  r_sticky, w_sticky_nx;
  logic [ACC_WIDTH-1:0]  r_data, w_data_nx;
  logic                  r_sat, w_sat_nx;
  logic                  w_valid_nx;
  logic [ACC_WIDTH:0]    w_sum;
  logic                  w_ovf;
  logic [ACC_WIDTH-1:0]  w_sat_sum;

  assign w_sum     = {1'b0, r_acc} + (ACC_WIDTH+1)'(w_root);
  assign w_ovf     = w_sum[ACC_WIDTH];
  assign w_sat_sum = w_ovf ? '1 : w_sum[ACC_WIDTH-1:0];

  always_comb begin
    w_state_nx  = r_state;
    w_acc_nx    = r_acc;
    w_sticky_nx = r_sticky;
    w_data_nx   = r_data;
    w_sat_nx    = r_sat;
    w_valid_nx  = r_valid;
    if (w_adv) begin
      w_valid_nx = 1'b0;
      if (r_vld_pipe[LEVELS]) begin
        if (!r_acc_pipe[LEVELS]) begin
          w_valid_nx = 1'b1;
          w_data_nx  = ACC_WIDTH'(w_root);
          w_sat_nx   = 1'b0;
        end else if (!r_last_pipe[LEVELS]) begin
          w_acc_nx    = w_sat_sum;
          w_sticky_nx = r_sticky | w_ovf;
          w_state_nx  = S_ACCUM;
        end else begin
          w_valid_nx  = 1'b1;
          w_data_nx   = w_sat_sum;
          w_sat_nx    = r_sticky | w_ovf;
          w_acc_nx    = '0;
          w_sticky_nx = 1'b0;
          w_state_nx  = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_sticky <= 1'b0;
      r_data   <= '0;
      r_sat    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_acc    <= w_acc_nx;
      r_sticky <= w_sticky_nx;
      r_data   <= w_data_nx;
      r_sat    <= w_sat_nx;
      r_valid  <= w_valid_nx;
    end
  end

  assign o_valid        = r_valid;
  assign o_data         = r_data;
  assign o_sat          = r_sat;
  assign o_accum_active = (r_state == S_ACCUM);
endmodule

// File: tb/tb_pop_counter_pipe.sv
// Scoreboard bench for pop_counter_pipe (WIDTH=64, ACC_WIDTH=7): directed cases
// from the block's intended use plus randomized beats, packets and backpressure.

module tb_pop_counter_pipe;
  localparam int W  = 64;
  localparam int AW = 7;
  localparam int MAXV = (1 << AW) - 1;

  logic          clk = 0;
  logic          i_rst = 1;
  logic          i_valid = 0;
  logic          o_ready;
  logic [W-1:0]  i_data = '0;
  logic          i_accum = 0;
  logic          i_last = 0;
  logic          o_valid;
  logic          i_ready = 1;
  logic [AW-1:0] o_data;
  logic          o_sat;
  logic          o_accum_active;
`ifdef POP_COUNTER_PIPE_MASK_EN
  logic [W-1:0]  i_mask = '1;
`endif

  pop_counter_pipe #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data),
`ifdef POP_COUNTER_PIPE_MASK_EN
    .i_mask(i_mask),
`endif
    .i_accum(i_accum), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_sat(o_sat), .o_accum_active(o_accum_active));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int exp_data[$];
  bit exp_sat[$];
  int out_cyc[$];
  int tot = 0;          // running packet total, unbounded
  bit rand_ready = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: count bits, sum packets without bound, clamp only at emission.
  task automatic model_accept(input logic [W-1:0] bits, input bit acc, input bit lst);
    int c = $countones(bits);
    if (!acc) begin
      exp_data.push_back(c); exp_sat.push_back(0);
    end else begin
      tot += c;
      if (lst) begin
        exp_data.push_back(tot > MAXV ? MAXV : tot);
        exp_sat.push_back(tot > MAXV);
        tot = 0;
      end
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] m, input bit acc, input bit lst);
    int n = 0;
    bit done = 0;
    logic [W-1:0] cnt_bits = d;
`ifdef POP_COUNTER_PIPE_MASK_EN
    i_mask = m;
    cnt_bits = d & m;
`endif
    i_valid = 1; i_data = d; i_accum = acc; i_last = lst;
    while (!done) begin
      @(negedge clk);
      if (o_ready) begin
        model_accept(cnt_bits, acc, lst);
        done = 1;
      end else if (++n > 200) begin
        chk("send_timeout", 0, 1);
        done = 1;
      end
      @(posedge clk); #1;
    end
    i_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_data.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", exp_data.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1; i_valid = 0;
    exp_data.delete(); exp_sat.delete(); tot = 0;
    repeat (3) @(posedge clk);
    #1 i_rst = 0;
  endtask

  // Monitor: pops on every accepted result, checks holding during stalls.
  bit stalled = 0;
  logic [AW-1:0] h_data;
  logic h_sat;
  always @(negedge clk) begin
    if (i_rst) stalled = 0;
    else begin
      if (stalled) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_data", o_data, h_data);
        chk("hold_sat", o_sat, h_sat);
      end
      if (o_valid && !i_ready) chk("stall_oready", o_ready, 0);
      if (o_valid && i_ready) begin
        if (exp_data.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          chk("out_data", o_data, exp_data.pop_front());
          chk("out_sat", o_sat, exp_sat.pop_front());
          out_cyc.push_back(cyc);
        end
      end
      stalled = o_valid && !i_ready;
      h_data = o_data; h_sat = o_sat;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
  end

  logic [W-1:0] ONES = '1;
  logic [W-1:0] bb[4];

  initial begin
    int lat;
    bb[0] = 64'h0; bb[1] = 64'h1; bb[2] = 64'h8000_0000_0000_0001; bb[3] = 64'hAAAA_AAAA_AAAA_AAAA;
    do_reset();
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_active", o_accum_active, 0);
    chk("rst_ready", o_ready, 1);
    @(posedge clk); #1;

    // Latency of a single all-ones beat
    i_valid = 1; i_data = ONES; i_accum = 0; i_last = 0;
`ifdef POP_COUNTER_PIPE_MASK_EN
    i_mask = ONES;
`endif
    @(negedge clk);
    chk("lat_ready", o_ready, 1);
    model_accept(ONES, 0, 0);
    @(posedge clk); #1 i_valid = 0;
    lat = 0;
    do begin
      lat++;
      @(negedge clk);
      if (o_valid) break;
      @(posedge clk);
    end while (lat < 20);
    chk("latency", lat, 6);
    drain();

    // Back-to-back beats produce consecutive results
    out_cyc.delete();
    for (int i = 0; i < 4; i++) send(bb[i], ONES, 0, 0);
    drain();
    chk("b2b_count", out_cyc.size(), 4);
    for (int i = 1; i < out_cyc.size(); i++) chk("b2b_consecutive", out_cyc[i] - out_cyc[0], i);

    // Same stream with a 3-cycle downstream stall
    fork
      for (int i = 0; i < 4; i++) send(bb[i], ONES, 0, 0);
      begin repeat (7) @(posedge clk); #1 i_ready = 0; repeat (3) @(posedge clk); #1 i_ready = 1; end
    join
    drain();

    // Three-beat packet 10+20+30
    send(64'h3FF, ONES, 1, 0);
    send(64'hF_FFFF, ONES, 1, 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("pkt_active", o_accum_active, 1);
    chk("pkt_no_output", o_valid, 0);
    @(posedge clk); #1;
    send(64'h3FFF_FFFF, ONES, 1, 1);
    drain();
    chk("pkt_idle", o_accum_active, 0);

    // Saturating packet then a small packet clears the flag
    for (int i = 0; i < 3; i++) send(ONES, ONES, 1, i == 2);
    send(64'h3, ONES, 1, 1);
    drain();

    // Reset mid-packet discards everything in flight
    send(ONES, ONES, 1, 0);
    send(ONES, ONES, 1, 0);
    do_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_rst_valid", o_valid, 0);
    chk("post_rst_active", o_accum_active, 0);
    @(posedge clk); #1;
    send(64'hF, ONES, 1, 1);
    drain();
`ifdef POP_COUNTER_PIPE_MASK_EN
    send(ONES, 64'h00FF, 0, 0);
    drain();
`endif

    // Randomized beats, packets and backpressure
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] d, m;
      int k = $urandom_range(0, 9);
      d = {$urandom, $urandom};
      if (k == 0) d = ONES;
      else if (k == 1) d = '0;
      m = ($urandom_range(0, 1) != 0) ? ONES : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(d, m, $urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0);
    end
    rand_ready = 0;
    @(posedge clk); #1 i_ready = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
